multiplicador_secuencial: RTL
=============================

// Module: multiplicador_secuencial
// PURPOSE
//  Multi-cycle radix-2 shift-add multiplier for the ALU. Sits directly around the WORD-bit
//  ripple adder: drives its opea/opeb/cin every cycle and consumes sal/cout to build a
//  2*WORD product. Used for MUL/MULH-class ops; the core stalls on ocupado.
// PARAMETERS
//  WORD     32   operand width; product is 2*WORD bits
// PORTS
//  clk        in   1     clock, rising edge
//  rst_n      in   1     reset, asynchronous, active-low
//  inicio     in   1     start request; sampled only in REPOSO or FIN
//  con_signo  in   1     1 = two's-complement operands, 0 = unsigned
//  opea       in   WORD  multiplicand
//  opeb       in   WORD  multiplier
//  ocupado    out  1     high from the edge after inicio is accepted until FIN is reached
//  listo      out  1     one-cycle pulse in FIN: prod_alto/prod_bajo valid
//  prod_alto  out  WORD  product bits [2*WORD-1:WORD]
//  prod_bajo  out  WORD  product bits [WORD-1:0]
// BEHAVIOUR
//  Reset (rst_n=0, async): state=REPOSO; ocupado=0, listo=0, prod_alto=0, prod_bajo=0,
//   internal M, neg, carry regs = 0. Reset mid-operation aborts; no listo is produced.
//  States: REPOSO -> MULT -> CORR_BAJO -> CORR_ALTO -> FIN -> REPOSO (or MULT).
//  Accept (edge 0, state REPOSO/FIN, inicio=1): M <= |opea|, prod_bajo <= |opeb|,
//   prod_alto <= 0, neg <= con_signo & (opea[WORD-1] ^ opeb[WORD-1]), cnt <= 0, go MULT.
//   |x| = x when con_signo=0 or x>=0; else ~x+1 via dedicated logic (not the shared adder).
//   |-2^(WORD-1)| = 2^(WORD-1) as unsigned WORD bits -- correct, no overflow handling.
//  MULT (exactly WORD cycles, edges 1..WORD): adder opea=prod_alto, opeb=prod_bajo[0]?M:0,
//   cin=0; {prod_alto,prod_bajo} <= {cout, sal, prod_bajo[WORD-1:1]}. cnt+1; on cnt=WORD-1 go
//   CORR_BAJO. No early exit for zero operands: latency is fixed.
//  CORR_BAJO (edge WORD+1): if neg: adder opea=~prod_bajo, opeb=0, cin=1; prod_bajo <= sal,
//   carry <= cout. If !neg: registers unchanged, carry <= 0.
//  CORR_ALTO (edge WORD+2): if neg: adder opea=~prod_alto, opeb=0, cin=carry; prod_alto <= sal.
//  FIN: listo=1 for exactly one cycle, ocupado=0. Next edge: REPOSO, or MULT if inicio=1
//   (back-to-back accepted; listo not extended).
//  Latency: listo high in the cycle after edge WORD+2 (34 cycles after accept for WORD=32).
//  inicio while ocupado=1: ignored, no queuing. Operand inputs sampled only at accept edge.
//  prod_alto/prod_bajo are the working registers: undefined to consumers while ocupado=1;
//   hold the final product from FIN until the next accept edge.
//  Width rule: product always full 2*WORD; unsigned result never exceeds (2^WORD-1)^2.
//  Adder cin tied 0 except in CORR_* states as above; adder cout ignored outside MULT/CORR_BAJO.
// STRUCTURE
//  Shared package alu_pkg: WORD default, state encoding constants
//   (REPOSO=3'd0, MULT=3'd1, CORR_BAJO=3'd2, CORR_ALTO=3'd3, FIN=3'd4).
//  One sub-module instance: Sumador #(.WORD(WORD)) u_sumador -- the only adder in the datapath;
//   absolute-value negation at accept uses local logic.
//  Counter width $clog2(WORD); 1-process state register, combinational next-state/mux logic.
// TESTING
//  unsigned 7 x 6 -> listo at cycle 34, prod_alto=0, prod_bajo=42.
//  unsigned 0xFFFFFFFF x 0xFFFFFFFF -> prod_alto=0xFFFFFFFE, prod_bajo=0x00000001.
//  signed -3 x 5 -> prod_alto=0xFFFFFFFF, prod_bajo=0xFFFFFFF1; signed -3 x -5 -> 0:15.
//  signed 0x80000000 x 0x80000000 -> prod_alto=0x40000000, prod_bajo=0x00000000.
//  inicio pulsed at cycle 10 of an op -> ignored, result of first op unchanged; inicio in FIN
//   -> second op accepted, listo again exactly 34 cycles later.
//  rst_n low at cycle 15 of an op -> all outputs 0 immediately, no listo; fresh op then correct.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: default datapath width and the sequential multiplier state encoding.
package alu_pkg;

    localparam int WORD_DEF = 32;

    typedef enum logic [2:0] {
        REPOSO    = 3'd0,
        MULT      = 3'd1,
        CORR_BAJO = 3'd2,
        CORR_ALTO = 3'd3,
        FIN       = 3'd4
    } estado_t;

endpackage

// File: rtl/multiplicador_secuencial_sumador.sv
// WORD-bit adder with carry in/out; the single adder shared by the multiplier datapath.
module Sumador #(
    parameter int WORD = 32
) (
    input  logic [WORD-1:0] opea,
    input  logic [WORD-1:0] opeb,
    input  logic            cin,
    output logic [WORD-1:0] sal,
    output logic            cout
);

    assign {cout, sal} = {1'b0, opea} + {1'b0, opeb} + {{WORD{1'b0}}, cin};

endmodule

// File: rtl/multiplicador_secuencial.sv
// Radix-2 shift-add multiplier: WORD accumulate cycles on the shared adder, then a two-cycle
// two's-complement fixup (low half, then high half) when the signed result is negative.
//
//  state     | meaning
//  REPOSO    | idle, waiting for inicio
//  MULT      | one shift-add step per cycle, WORD cycles
//  CORR_BAJO | negate low half if result is negative, keep carry
//  CORR_ALTO | negate high half using the saved carry
//  FIN       | product valid, listo pulses; may accept a new operation
module multiplicador_secuencial
    import alu_pkg::*;
#(
    parameter int WORD = WORD_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            inicio,
    input  logic            con_signo,
    input  logic [WORD-1:0] opea,
    input  logic [WORD-1:0] opeb,
    output logic            ocupado,
    output logic            listo,
    output logic [WORD-1:0] prod_alto,
    output logic [WORD-1:0] prod_bajo
);

    localparam int CW = $clog2(WORD);
    localparam logic [CW-1:0] CNT_LAST = CW'(WORD - 1);

    estado_t         estado;
    logic [WORD-1:0] m;
    logic            neg;
    logic            carry;
    logic [CW-1:0]   cnt;

    logic [WORD-1:0] abs_a;
    logic [WORD-1:0] abs_b;
    logic [WORD-1:0] add_a;
    logic [WORD-1:0] add_b;
    logic            add_cin;
    logic [WORD-1:0] add_sal;
    logic            add_cout;

    // Operand magnitudes use local negation so the shared adder stays free at accept.
    always_comb begin
        abs_a = opea;
        abs_b = opeb;
        if (con_signo && opea[WORD-1]) abs_a = ~opea + 1'b1;
        if (con_signo && opeb[WORD-1]) abs_b = ~opeb + 1'b1;
    end

    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        case (estado)
            MULT: begin
                add_a = prod_alto;
                add_b = prod_bajo[0] ? m : '0;
            end
            CORR_BAJO: begin
                if (neg) begin
                    add_a   = ~prod_bajo;
                    add_cin = 1'b1;
                end
            end
            CORR_ALTO: begin
                if (neg) begin
                    add_a   = ~prod_alto;
                    add_cin = carry;
                end
            end
            default: ;
        endcase
    end

    Sumador #(.WORD(WORD)) u_sumador (
        .opea (add_a),
        .opeb (add_b),
        .cin  (add_cin),
        .sal  (add_sal),
        .cout (add_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado    <= REPOSO;
            ocupado   <= 1'b0;
            listo     <= 1'b0;
            prod_alto <= '0;
            prod_bajo <= '0;
            m         <= '0;
            neg       <= 1'b0;
            carry     <= 1'b0;
            cnt       <= '0;
        end else begin
            case (estado)
                REPOSO, FIN: begin
                    listo <= 1'b0;
                    if (inicio) begin
                        m         <= abs_a;
                        prod_bajo <= abs_b;
                        prod_alto <= '0;
                        neg       <= con_signo & (opea[WORD-1] ^ opeb[WORD-1]);
                        cnt       <= '0;
                        ocupado   <= 1'b1;
                        estado    <= MULT;
                    end else begin
                        estado <= REPOSO;
                    end
                end
                MULT: begin
                    // Carry-out becomes the new MSB as the whole product shifts right.
                    {prod_alto, prod_bajo} <= {add_cout, add_sal, prod_bajo[WORD-1:1]};
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) estado <= CORR_BAJO;
                end
                CORR_BAJO: begin
                    if (neg) begin
                        prod_bajo <= add_sal;
                        carry     <= add_cout;
                    end else begin
                        carry <= 1'b0;
                    end
                    estado <= CORR_ALTO;
                end
                CORR_ALTO: begin
                    if (neg) prod_alto <= add_sal;
                    ocupado <= 1'b0;
                    listo   <= 1'b1;
                    estado  <= FIN;
                end
                default: begin
                    ocupado <= 1'b0;
                    listo   <= 1'b0;
                    estado  <= REPOSO;
                end
            endcase
        end
    end

endmodule
